fetch_stage: RTL and testbench

//  PC generator plus IF/ID pipeline register for the vector CPU fetch path.
//  - Drives the word-index PC into the combinational instruction memory.
//  - Captures the returned word together with its PC into IF/ID for decode.
//  - Handles stall, flush, branch redirect and halt.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/fetch_stage_ifid_register.sv | 36 +++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch path.
//   fetch_state_t : fetch FSM encoding (RUN, HALTED)
//   ifid_t        : IF/ID pipeline register contents
//   NOP_WORD      : instruction word loaded into IF/ID on reset
//   HALT_WORD_DEFAULT : default encoding that stops fetch
package fetch_pkg;

    localparam int FETCH_PC_W    = 32;
    localparam int FETCH_INSTR_W = 32;

    localparam logic [FETCH_INSTR_W-1:0] NOP_WORD          = '0;
    localparam logic [FETCH_INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_PC_W-1:0]    pc_plus1;
        logic                     valid;
    } ifid_t;

    // Word-index PC wrap: the memory size is a power of two, so masking is
    // the same as taking the value modulo the memory size.
    function automatic logic [FETCH_PC_W-1:0] wrap_pc(
        input logic [FETCH_PC_W-1:0] pc,
        input logic [FETCH_PC_W-1:0] mask
    );
        return pc & mask;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_register.sv
// ifid_register: IF/ID pipeline register storage.
//   clk           : clock
//   reset         : synchronous active-high reset (NOP_WORD, pc 0, invalid)
//   load_i        : capture d_i
//   clear_valid_i : drop valid, keep instr/pc fields (ignored when load_i)
//   d_i           : next IF/ID contents
//   q_o           : current IF/ID contents
module ifid_register
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load_i,
    input  logic  clear_valid_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t ifid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q.instr    <= NOP_WORD;
            ifid_q.pc       <= '0;
            ifid_q.pc_plus1 <= '0;
            ifid_q.valid    <= 1'b0;
        end else if (load_i) begin
            ifid_q <= d_i;
        end else if (clear_valid_i) begin
            ifid_q.valid <= 1'b0;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC generator and IF/ID register for the vector CPU fetch path.
//   clk, reset       : clock, synchronous active-high reset
//   stall_i          : hold PC and IF/ID
//   flush_i          : invalidate IF/ID on the next edge
//   redirect_i       : load redirect_pc_i (masked to the memory range) into PC
//   redirect_pc_i    : redirect target
//   imem_pc_o        : PC to the combinational instruction memory
//   imem_instr_i     : word at imem_pc_o, same cycle
//   ifid_instr_o / ifid_pc_o / ifid_pc_plus1_o / ifid_valid_o : IF/ID contents
//   halted_o         : fetch is stopped on a halt word
// Optional feature macro FETCH_PERF_EN adds fetch_count_o and stall_count_o.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                          PC_WIDTH          = FETCH_PC_W,
    parameter int                          INSTRUCTION_WIDTH = FETCH_INSTR_W,
    parameter int                          MEMORY_SIZE       = 1024,
    parameter logic [PC_WIDTH-1:0]         RESET_PC          = '0,
    parameter logic [INSTRUCTION_WIDTH-1:0] HALT_WORD        = HALT_WORD_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         redirect_i,
    input  logic [PC_WIDTH-1:0]          redirect_pc_i,
    output logic [PC_WIDTH-1:0]          imem_pc_o,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_instr_i,
    output logic [INSTRUCTION_WIDTH-1:0] ifid_instr_o,
    output logic [PC_WIDTH-1:0]          ifid_pc_o,
    output logic [PC_WIDTH-1:0]          ifid_pc_plus1_o,
    output logic                         ifid_valid_o,
    output logic                         halted_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                  fetch_count_o,
    output logic [31:0]                  stall_count_o
`endif
);

    // The IF/ID struct lives in the package with fixed field widths.
    if (PC_WIDTH != FETCH_PC_W || INSTRUCTION_WIDTH != FETCH_INSTR_W) begin : g_width_check
        $error("fetch_stage: PC_WIDTH/INSTRUCTION_WIDTH must match fetch_pkg widths");
    end
    if (MEMORY_SIZE < 2 || (MEMORY_SIZE & (MEMORY_SIZE - 1)) != 0) begin : g_size_check
        $error("fetch_stage: MEMORY_SIZE must be a power of two");
    end

    localparam logic [PC_WIDTH-1:0] PC_MASK = PC_WIDTH'(MEMORY_SIZE - 1);

    fetch_state_t        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                halted_q, halted_d;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                ifid_load;
    logic                ifid_clear;
    ifid_t               ifid_d;
    ifid_t               ifid_q;

    assign pc_inc = wrap_pc(pc_q + PC_WIDTH'(1), PC_MASK);

    // Priority: redirect > HALTED hold > stall > flush > halt detect > advance.
    // HALTED is checked before stall so stall/flush cannot resurrect valid.
    always_comb begin
        pc_d           = pc_q;
        state_d        = state_q;
        halted_d       = halted_q;
        ifid_load      = 1'b0;
        ifid_clear     = 1'b0;
        ifid_d.instr    = imem_instr_i;
        ifid_d.pc       = pc_q;
        ifid_d.pc_plus1 = pc_inc;
        ifid_d.valid    = 1'b1;

        if (redirect_i) begin
            pc_d       = wrap_pc(redirect_pc_i, PC_MASK);
            ifid_clear = 1'b1;
            state_d    = RUN;
            halted_d   = 1'b0;
        end else if (state_q == HALTED) begin
            ifid_clear = 1'b1;
        end else if (stall_i) begin
            ifid_clear = flush_i;
        end else if (flush_i) begin
            ifid_clear = 1'b1;
            pc_d       = pc_inc;
        end else if (imem_instr_i == HALT_WORD) begin
            // Halt word is delivered to decode; PC parks on it.
            ifid_load  = 1'b1;
            state_d    = HALTED;
            halted_d   = 1'b1;
        end else begin
            ifid_load  = 1'b1;
            pc_d       = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= wrap_pc(RESET_PC, PC_MASK);
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    ifid_register u_ifid (
        .clk          (clk),
        .reset        (reset),
        .load_i       (ifid_load),
        .clear_valid_i(ifid_clear),
        .d_i          (ifid_d),
        .q_o          (ifid_q)
    );

    assign imem_pc_o       = pc_q;
    assign ifid_instr_o    = ifid_q.instr;
    assign ifid_pc_o       = ifid_q.pc;
    assign ifid_pc_plus1_o = ifid_q.pc_plus1;
    assign ifid_valid_o    = ifid_q.valid;
    assign halted_o        = halted_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (ifid_load) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (stall_i && state_q == RUN) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count_o = fetch_count_q;
    assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_pkg::*;

    typedef logic [96:0] exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_en = 1'b0;

    logic [31:0] imem_pc, imem_instr, ifid_instr, ifid_pc, ifid_pc1;
    logic        ifid_valid, halted;
    logic [31:0] imem_pc16, imem_instr16, ifid_instr16, ifid_pc16, ifid_pc1_16;
    logic        ifid_valid16, halted16;
`ifdef FETCH_PERF_EN
    logic [31:0] fcnt, scnt, fcnt16, scnt16;
`endif

    int   n_assert = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t got, exp;

    always #5 clk = ~clk;

    // mem[k] = k+100, optionally with HALT_WORD at word 9
    always_comb imem_instr   = (halt_en && imem_pc == 32'd9)   ? 32'hFFFF_FFFF : imem_pc + 32'd100;
    always_comb imem_instr16 = (halt_en && imem_pc16 == 32'd9) ? 32'hFFFF_FFFF : imem_pc16 + 32'd100;

    fetch_stage #(.MEMORY_SIZE(64)) u_dut (
        .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_pc_o(imem_pc), .imem_instr_i(imem_instr),
        .ifid_instr_o(ifid_instr), .ifid_pc_o(ifid_pc), .ifid_pc_plus1_o(ifid_pc1),
        .ifid_valid_o(ifid_valid), .halted_o(halted)
`ifdef FETCH_PERF_EN
        , .fetch_count_o(fcnt), .stall_count_o(scnt)
`endif
    );

    fetch_stage #(.MEMORY_SIZE(16)) u_dut16 (
        .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_pc_o(imem_pc16), .imem_instr_i(imem_instr16),
        .ifid_instr_o(ifid_instr16), .ifid_pc_o(ifid_pc16), .ifid_pc_plus1_o(ifid_pc1_16),
        .ifid_valid_o(ifid_valid16), .halted_o(halted16)
`ifdef FETCH_PERF_EN
        , .fetch_count_o(fcnt16), .stall_count_o(scnt16)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_assert++;
        if (imem_pc !== 32'd0) begin
            n_fail++; $display("FAIL reset_pc: got %0d want 0", imem_pc);
        end
        got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
        n_assert++;
        if (got !== 97'd0) begin
            n_fail++; $display("FAIL reset_ifid: got %h want 0", got);
        end
        n_assert++;
        if (halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_halted: got %b want 0", halted);
        end
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (imem_pc !== 32'(i)) begin
                n_fail++; $display("FAIL seq_pc: got %0d want %0d", imem_pc, i);
            end
            sb.push_back({32'(i + 100), 32'(i), 32'(i + 1), 1'b1});
            step();
            exp = sb.pop_front();
            got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
            n_assert++;
            if (got !== exp) begin
                n_fail++; $display("FAIL seq_ifid: got %h want %h", got, exp);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 3; i < 5; i++) begin
            sb.push_back({32'(i + 100), 32'(i), 32'(i + 1), 1'b1});
            step();
            exp = sb.pop_front();
            got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
            n_assert++;
            if (got !== exp) begin
                n_fail++; $display("FAIL stall_pre_ifid: got %h want %h", got, exp);
            end
        end
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_assert++;
            if (imem_pc !== 32'd5) begin
                n_fail++; $display("FAIL stall_pc: got %0d want 5", imem_pc);
            end
            got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
            n_assert++;
            if (got !== {32'd104, 32'd4, 32'd5, 1'b1}) begin
                n_fail++; $display("FAIL stall_ifid: got %h want %h", got, {32'd104, 32'd4, 32'd5, 1'b1});
            end
        end
        stall = 1'b0;
        sb.push_back({32'd105, 32'd5, 32'd6, 1'b1});
        step();
        exp = sb.pop_front();
        got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
        n_assert++;
        if (got !== exp) begin
            n_fail++; $display("FAIL stall_release_ifid: got %h want %h", got, exp);
        end
        n_assert++;
        if (imem_pc !== 32'd6) begin
            n_fail++; $display("FAIL stall_release_pc: got %0d want 6", imem_pc);
        end
    endtask

    task automatic test_redirect();
        sb.push_back({32'd106, 32'd6, 32'd7, 1'b1});
        step();
        exp = sb.pop_front();
        got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
        n_assert++;
        if (got !== exp) begin
            n_fail++; $display("FAIL redir_pre_ifid: got %h want %h", got, exp);
        end
        redirect = 1'b1;
        redirect_pc = 32'd40;
        step();
        redirect = 1'b0;
        n_assert++;
        if (imem_pc !== 32'd40) begin
            n_fail++; $display("FAIL redir_pc: got %0d want 40", imem_pc);
        end
        n_assert++;
        if (ifid_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_valid: got %b want 0", ifid_valid);
        end
        sb.push_back({32'd140, 32'd40, 32'd41, 1'b1});
        step();
        exp = sb.pop_front();
        got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
        n_assert++;
        if (got !== exp) begin
            n_fail++; $display("FAIL redir_target_ifid: got %h want %h", got, exp);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_assert++;
        if (ifid_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid: got %b want 0", ifid_valid);
        end
        n_assert++;
        if (imem_pc !== 32'd42) begin
            n_fail++; $display("FAIL flush_pc: got %0d want 42", imem_pc);
        end
        sb.push_back({32'd142, 32'd42, 32'd43, 1'b1});
        step();
        exp = sb.pop_front();
        got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
        n_assert++;
        if (got !== exp) begin
            n_fail++; $display("FAIL flush_after_ifid: got %h want %h", got, exp);
        end
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        n_assert++;
        if (imem_pc !== 32'd43) begin
            n_fail++; $display("FAIL stallflush_pc: got %0d want 43", imem_pc);
        end
        got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
        n_assert++;
        if (got !== {32'd142, 32'd42, 32'd43, 1'b0}) begin
            n_fail++; $display("FAIL stallflush_ifid: got %h want %h", got, {32'd142, 32'd42, 32'd43, 1'b0});
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) step();
        n_assert++;
        if (imem_pc16 !== 32'd15) begin
            n_fail++; $display("FAIL wrap_pre_pc: got %0d want 15", imem_pc16);
        end
        step();
        got = {ifid_instr16, ifid_pc16, ifid_pc1_16, ifid_valid16};
        n_assert++;
        if (got !== {32'd115, 32'd15, 32'd0, 1'b1}) begin
            n_fail++; $display("FAIL wrap_ifid: got %h want %h", got, {32'd115, 32'd15, 32'd0, 1'b1});
        end
        n_assert++;
        if (imem_pc16 !== 32'd0) begin
            n_fail++; $display("FAIL wrap_pc: got %0d want 0", imem_pc16);
        end
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FF13;
        step();
        redirect = 1'b0;
        n_assert++;
        if (imem_pc16 !== 32'd3) begin
            n_fail++; $display("FAIL redir_trunc16: got %0d want 3", imem_pc16);
        end
        n_assert++;
        if (imem_pc !== 32'd19) begin
            n_fail++; $display("FAIL redir_trunc64: got %0d want 19", imem_pc);
        end
    endtask

    task automatic test_halt();
        reset = 1'b1;
        halt_en = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sb.push_back({32'(i + 100), 32'(i), 32'(i + 1), 1'b1});
            step();
            exp = sb.pop_front();
            got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
            n_assert++;
            if (got !== exp) begin
                n_fail++; $display("FAIL halt_pre_ifid: got %h want %h", got, exp);
            end
        end
        sb.push_back({32'hFFFF_FFFF, 32'd9, 32'd10, 1'b1});
        step();
        exp = sb.pop_front();
        got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
        n_assert++;
        if (got !== exp) begin
            n_fail++; $display("FAIL halt_ifid: got %h want %h", got, exp);
        end
        n_assert++;
        if (halted !== 1'b1) begin
            n_fail++; $display("FAIL halt_flag: got %b want 1", halted);
        end
        n_assert++;
        if (imem_pc !== 32'd9) begin
            n_fail++; $display("FAIL halt_pc: got %0d want 9", imem_pc);
        end
        step();
        n_assert++;
        if ({ifid_valid, halted, imem_pc} !== {1'b0, 1'b1, 32'd9}) begin
            n_fail++; $display("FAIL halted_hold: got valid=%b halted=%b pc=%0d want 0 1 9", ifid_valid, halted, imem_pc);
        end
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        n_assert++;
        if ({ifid_valid, halted, imem_pc} !== {1'b0, 1'b1, 32'd9}) begin
            n_fail++; $display("FAIL halted_stall: got valid=%b halted=%b pc=%0d want 0 1 9", ifid_valid, halted, imem_pc);
        end
        redirect = 1'b1;
        redirect_pc = 32'd0;
        step();
        redirect = 1'b0;
        n_assert++;
        if ({ifid_valid, halted, imem_pc} !== {1'b0, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL halt_exit: got valid=%b halted=%b pc=%0d want 0 0 0", ifid_valid, halted, imem_pc);
        end
        sb.push_back({32'd100, 32'd0, 32'd1, 1'b1});
        step();
        exp = sb.pop_front();
        got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
        n_assert++;
        if (got !== exp) begin
            n_fail++; $display("FAIL halt_resume_ifid: got %h want %h", got, exp);
        end
        halt_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b1;
        step();
        step();
`ifdef FETCH_PERF_EN
        n_assert++;
        if ({fcnt, scnt} !== {32'd3, 32'd2}) begin
            n_fail++; $display("FAIL perf_counts: got fetch=%0d stall=%0d want 3 2", fcnt, scnt);
        end
`endif
        reset = 1'b1;
        step();
        stall = 1'b0;
        n_assert++;
        if ({imem_pc, ifid_valid, halted} !== {32'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rst_midstall: got pc=%0d valid=%b halted=%b want 0 0 0", imem_pc, ifid_valid, halted);
        end
`ifdef FETCH_PERF_EN
        n_assert++;
        if ({fcnt, scnt} !== 64'd0) begin
            n_fail++; $display("FAIL rst_perf: got fetch=%0d stall=%0d want 0 0", fcnt, scnt);
        end
`endif
        reset = 1'b0;
        halt_en = 1'b1;
        for (int i = 0; i < 11; i++) step();
        n_assert++;
        if (halted !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_halted: got %b want 1", halted);
        end
        reset = 1'b1;
        step();
        halt_en = 1'b0;
        n_assert++;
        if ({imem_pc, ifid_valid, halted} !== {32'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rst_midhalt: got pc=%0d valid=%b halted=%b want 0 0 0", imem_pc, ifid_valid, halted);
        end
        reset = 1'b0;
        sb.push_back({32'd100, 32'd0, 32'd1, 1'b1});
        step();
        exp = sb.pop_front();
        got = {ifid_instr, ifid_pc, ifid_pc1, ifid_valid};
        n_assert++;
        if (got !== exp) begin
            n_fail++; $display("FAIL rst_resume_ifid: got %h want %h", got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
